// File: rtl/mod7_serial_ctrl.sv
// mod7_serial_ctrl: bit-serial remainder-mod-7 of a WIDTH-bit operand, one bit per clock,
// wrapped in an IDLE/RUN/DONE sequencer with valid/ready handshakes on both sides.
module mod7_serial_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_rem,
  output logic             out_div,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       acc_q, acc_d;
  logic [3:0]       word, red;
  logic             load, run;
  // acc <= 6 keeps word <= 13, so the mod-7 cell reduces to one conditional subtract
  always_comb begin
    word    = {acc_q, shift_q[WIDTH-1]};
    red     = word >= 4'd7 ? word - 4'd7 : word;
    load    = state_q == IDLE && in_valid;
    run     = state_q == RUN;
    state_d = state_q == IDLE ? (in_valid ? RUN : IDLE)
            : state_q == RUN  ? (cnt_q == CW'(1) ? DONE : RUN)
            : state_q == DONE ? (out_ready ? IDLE : DONE)
            : IDLE;
    shift_d = load ? in_data : run ? shift_q << 1 : shift_q;
    cnt_d   = load ? CW'(WIDTH) : run ? cnt_q - CW'(1) : cnt_q;
    acc_d   = load ? 3'd0 : run ? red[2:0] : acc_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end
  assign in_ready  = state_q == IDLE && !rst;
  assign out_valid = state_q == DONE;
  assign busy      = state_q == RUN || state_q == DONE;
  assign out_rem   = acc_q;
  assign out_div   = acc_q == 3'd0;
endmodule

// File: tb/tb_mod7_serial_ctrl.sv
// tb_mod7_serial_ctrl: scoreboard bench for WIDTH=16, 4 and 32 instances of mod7_serial_ctrl.
module tb_mod7_serial_ctrl;
  typedef struct {logic [2:0] rem; int t;} exp_t;
  logic clk = 0;
  logic rst = 1;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  logic a_iv = 0, a_ir, a_ov, a_or = 1, a_div, a_busy;
  logic [15:0] a_id = 0;
  logic [2:0] a_rem;
  logic b_iv = 0, b_ir, b_ov, b_or = 1, b_div, b_busy;
  logic [3:0] b_id = 0;
  logic [2:0] b_rem;
  logic c_iv = 0, c_ir, c_ov, c_or = 1, c_div, c_busy;
  logic [31:0] c_id = 0;
  logic [2:0] c_rem;
  exp_t qa[$], qb[$], qc[$];
  exp_t ea, eb, ec;
  mod7_serial_ctrl #(.WIDTH(16)) u_a (.clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir),
    .in_data(a_id), .out_valid(a_ov), .out_ready(a_or), .out_rem(a_rem), .out_div(a_div), .busy(a_busy));
  mod7_serial_ctrl #(.WIDTH(4)) u_b (.clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir),
    .in_data(b_id), .out_valid(b_ov), .out_ready(b_or), .out_rem(b_rem), .out_div(b_div), .busy(b_busy));
  mod7_serial_ctrl #(.WIDTH(32)) u_c (.clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir),
    .in_data(c_id), .out_valid(c_ov), .out_ready(c_or), .out_rem(c_rem), .out_div(c_div), .busy(c_busy));
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask
  logic [2:0] a_hold;
  logic a_prev = 0;
  int a_rise = 0;
  int a_hs = 0;
  always @(negedge clk) begin
    if (a_ov) begin
      if (!a_prev) a_rise = cyc;
      else begin
        chk("a_hold_rem", a_rem, a_hold);
        chk("a_hold_div", a_div, a_hold == 0);
      end
      a_hold = a_rem;
      chk("a_in_ready_in_done", a_ir, 0);
      if (a_or) begin
        if (qa.size() == 0) chk("a_unexpected_valid", 1, 0);
        else begin
          ea = qa.pop_front();
          chk("a_rem", a_rem, ea.rem);
          chk("a_div", a_div, ea.rem == 0);
          chk("a_latency", a_rise - ea.t, 16);
        end
        a_hs = cyc + 1;
      end
    end
    a_prev = a_ov;
  end
  always @(negedge clk) if (b_ov) begin
    if (qb.size() == 0) chk("b_unexpected_valid", 1, 0);
    else begin
      eb = qb.pop_front();
      chk("b_rem", b_rem, eb.rem);
      chk("b_div", b_div, eb.rem == 0);
      chk("b_latency", cyc - eb.t, 4);
    end
  end
  always @(negedge clk) if (c_ov) begin
    if (qc.size() == 0) chk("c_unexpected_valid", 1, 0);
    else begin
      ec = qc.pop_front();
      chk("c_rem", c_rem, ec.rem);
      chk("c_latency", cyc - ec.t, 32);
    end
  end
  task automatic send_a(input logic [15:0] d, input logic [2:0] r, input bit track, output int t);
    int n = 0;
    @(negedge clk);
    while (!a_ir && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!a_ir) chk("a_in_ready_timeout", 0, 1);
    a_iv = 1;
    a_id = d;
    @(negedge clk);
    a_iv = 0;
    t = cyc;
    if (track) qa.push_back('{r, cyc});
  endtask
  task automatic drain(input int which);
    int n = 0;
    while ((which == 0 ? qa.size() : which == 1 ? qb.size() : qc.size()) != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", which == 0 ? qa.size() : which == 1 ? qb.size() : qc.size(), 0);
  endtask
  initial begin
    int t, n;
    logic [31:0] v;
    logic [15:0] bvec [4] = '{16'h0000, 16'hFFFF, 16'd49, 16'd13};
    logic [2:0]  brem [4] = '{3'd0, 3'd1, 3'd0, 3'd6};
    repeat (2) @(negedge clk);
    chk("rst_out_valid", a_ov, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_out_rem", a_rem, 0);
    chk("rst_out_div", a_div, 1);
    chk("rst_in_ready_low", a_ir, 0);
    rst = 0;
    @(negedge clk);
    chk("in_ready_after_release", a_ir, 1);
    send_a(16'd100, 3'd2, 1, t);
    drain(0);
    for (int i = 0; i < 4; i++) begin
      send_a(bvec[i], brem[i], 1, t);
      if (i > 0) chk("boundary_accept_gap", t - a_hs, 1);
    end
    drain(0);
    @(posedge clk);
    #1 a_or = 0;
    send_a(16'd50, 3'd1, 1, t);
    n = 0;
    while (!a_ov && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_reached_done", a_ov, 1);
    a_iv = 1;
    a_id = 16'd9;
    repeat (5) begin
      @(negedge clk);
      chk("bp_out_valid_held", a_ov, 1);
      chk("bp_busy", a_busy, 1);
    end
    @(posedge clk);
    #1 a_or = 1;
    n = 0;
    @(negedge clk);
    while (!a_ir && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    a_iv = 0;
    qa.push_back('{3'd2, cyc});
    chk("bp_accept_after_handshake", cyc - a_hs, 1);
    drain(0);
    send_a(16'd1000, 3'd6, 0, t);
    repeat (8) @(posedge clk);
    #2 rst = 1;
    #1;
    chk("midrun_rst_out_valid", a_ov, 0);
    chk("midrun_rst_busy", a_busy, 0);
    chk("midrun_rst_out_rem", a_rem, 0);
    chk("midrun_rst_out_div", a_div, 1);
    chk("midrun_rst_in_ready", a_ir, 0);
    @(negedge clk);
    rst = 0;
    repeat (30) @(negedge clk);
    send_a(16'd20, 3'd6, 1, t);
    drain(0);
    for (int k = 0; k < 16; k++) begin
      n = 0;
      @(negedge clk);
      while (!b_ir && n < 50) begin
        @(negedge clk);
        n++;
      end
      b_iv = 1;
      b_id = 4'(k);
      @(negedge clk);
      b_iv = 0;
      qb.push_back('{3'(k % 7), cyc});
    end
    drain(1);
    for (int k = 0; k < 1000; k++) begin
      v = k < 2 ? (k == 0 ? 32'hFFFF_FFFF : 32'd0) : $urandom;
      n = 0;
      @(negedge clk);
      while (!c_ir && n < 100) begin
        @(negedge clk);
        n++;
      end
      c_iv = 1;
      c_id = v;
      @(negedge clk);
      c_iv = 0;
      qc.push_back('{3'(v % 32'd7), cyc});
    end
    drain(2);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
